bpsk_tx_sequencer: RTL and testbench

BPSK_TX_SEQUENCER -- requirements
Module: bpsk_tx_sequencer

---
 rtl/bpsk_tx_sequencer.sv | 142 ++++++++++++++
 tb/tb_bpsk_tx_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_sequencer.sv
// BPSK transmit sequencer: pulls data words over a valid/ready handshake and
// steps the carrier ROM address through SAMPLE_NUMBER samples per symbol bit.
module bpsk_tx_sequencer #(
  parameter int unsigned SAMPLE_NUMBER = 256,
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned FRAME_WIDTH   = 8,
  localparam int unsigned ADDR_WIDTH   = $clog2(SAMPLE_NUMBER),
  localparam int unsigned BIT_WIDTH    = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [FRAME_WIDTH-1:0] frame_len,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [ADDR_WIDTH-1:0]  cnt_out,
  output logic                   mod_en,
  output logic [DATA_WIDTH-1:0]  mod_data,
  output logic [BIT_WIDTH-1:0]   bit_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun
);

  typedef enum logic [1:0] {StIdle, StFetch, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [FRAME_WIDTH-1:0] words_q, words_d;
  logic                   underrun_q, underrun_d;
  logic                   mod_en_q, busy_q, done_q;
  logic                   last_sample, more_words;

  assign last_sample = (cnt_q == ADDR_WIDTH'(SAMPLE_NUMBER - 1)) && (bit_q == '0);
  assign more_words  = words_q > FRAME_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    words_d    = words_q;
    underrun_d = underrun_q;
    s_ready    = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start && (frame_len != '0)) begin
          state_d    = StFetch;
          words_d    = frame_len;
          underrun_d = 1'b0;
        end
      end
      StFetch: begin
        s_ready = 1'b1;
        cnt_d   = '0;
        if (s_valid) begin
          data_d  = s_data;
          bit_d   = BIT_WIDTH'(DATA_WIDTH - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(SAMPLE_NUMBER - 1)) begin
          if (bit_q != '0) begin
            bit_d = bit_q - BIT_WIDTH'(1);
          end else if (more_words) begin
            // Word boundary: the next word must arrive this cycle to avoid a gap.
            s_ready = 1'b1;
            words_d = words_q - FRAME_WIDTH'(1);
            if (s_valid) begin
              data_d = s_data;
              bit_d  = BIT_WIDTH'(DATA_WIDTH - 1);
            end else begin
              underrun_d = 1'b1;
              state_d    = StFetch;
            end
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    // Abort drops the frame but leaves the last word and underrun status visible.
    if (abort) begin
      state_d    = StIdle;
      cnt_d      = '0;
      bit_d      = bit_q;
      data_d     = data_q;
      words_d    = words_q;
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      words_q    <= '0;
      underrun_q <= 1'b0;
      mod_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      words_q    <= words_d;
      underrun_q <= underrun_d;
      mod_en_q   <= (state_d == StRun);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

  assign cnt_out  = cnt_q;
  assign mod_en   = mod_en_q;
  assign mod_data = data_q;
  assign bit_idx  = bit_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Directed self-checking bench for bpsk_tx_sequencer with default parameters.
module tb_bpsk_tx_sequencer;

  localparam int unsigned SampleNumber = 256;
  localparam int unsigned DataWidth    = 12;
  localparam int unsigned WordCycles   = SampleNumber * DataWidth;

  logic        clk = 1'b0;
  logic        arst;
  logic        start, abort;
  logic [7:0]  frame_len;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  cnt_out;
  logic        mod_en;
  logic [11:0] mod_data;
  logic [3:0]  bit_idx;
  logic        busy, done, underrun;

  int n_tests = 0;
  int n_fail  = 0;

  int en_cnt, done_cnt, gap_cnt, seq_err, hs_cnt, first_hs;
  bit timed_out;
  logic [11:0] words [0:3];

  bpsk_tx_sequencer dut (
    .clk      (clk),
    .arst     (arst),
    .start    (start),
    .abort    (abort),
    .frame_len(frame_len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .cnt_out  (cnt_out),
    .mod_en   (mod_en),
    .mod_data (mod_data),
    .bit_idx  (bit_idx),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_cnt_out"}, 32'(cnt_out), 0);
    check({tag, "_mod_en"}, 32'(mod_en), 0);
    check({tag, "_mod_data"}, 32'(mod_data), 0);
    check({tag, "_bit_idx"}, 32'(bit_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_underrun"}, 32'(underrun), 0);
  endtask

  // Runs one frame from start to IDLE, checking every modulated sample against
  // the expected address, bit index and word. late: hold the second word back.
  task automatic run_frame(input logic [7:0] len, input bit late, input bit poke_start);
    int  cyc;
    bit  seen_en, hs, poked;
    int  exp_bit, exp_cnt;
    en_cnt = 0; done_cnt = 0; gap_cnt = 0; seq_err = 0; hs_cnt = 0;
    first_hs = -1; timed_out = 0;
    s_data  = words[0];
    s_valid = 1'b1;
    @(negedge clk);
    frame_len = len;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; seen_en = 0;
    while (busy) begin
      if (cyc >= 20000) begin
        timed_out = 1;
        break;
      end
      hs = 0; poked = 0;
      if (mod_en) begin
        exp_cnt = en_cnt % SampleNumber;
        exp_bit = DataWidth - 1 - (en_cnt % WordCycles) / SampleNumber;
        if (32'(cnt_out) != exp_cnt) seq_err++;
        if (32'(bit_idx) != exp_bit) seq_err++;
        if (mod_data !== words[en_cnt / WordCycles]) seq_err++;
        en_cnt++;
        seen_en = 1;
        if (poke_start && en_cnt == 1000) begin
          start     = 1'b1;
          frame_len = 8'd5;
          poked     = 1;
        end
      end else if (seen_en && !done) begin
        gap_cnt++;
      end
      if (done) done_cnt++;
      if (late && hs_cnt == 1 && !s_valid && gap_cnt == 11) s_valid = 1'b1;
      if (s_ready && s_valid) begin
        hs_cnt++;
        hs = 1;
        if (first_hs < 0) first_hs = cyc;
      end
      if (hs || poked) begin
        @(posedge clk);
        #1;
        if (hs) s_data = words[hs_cnt];
        if (hs && late && hs_cnt == 1) s_valid = 1'b0;
        if (poked) start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("frame_timeout", 32'(timed_out), 0);
  endtask

  initial begin
    int  wait_cyc;
    int  done_seen;
    words[0] = 12'hA5C;
    words[1] = 12'h3C1;
    words[2] = 12'h0F0;
    words[3] = 12'h000;
    arst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = '0;
    s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    arst = 1'b0;

    // Single word, data always available.
    run_frame(8'd1, 1'b0, 1'b0);
    check("f1_en_cycles", 32'(en_cnt), 3072);
    check("f1_done", 32'(done_cnt), 1);
    check("f1_seq", 32'(seq_err), 0);
    check("f1_first_hs", 32'(first_hs), 0);
    check("f1_hs", 32'(hs_cnt), 1);
    check("f1_underrun", 32'(underrun), 0);
    check("f1_gap", 32'(gap_cnt), 0);

    // Three back-to-back words, no gaps at the boundaries.
    run_frame(8'd3, 1'b0, 1'b0);
    check("f3_en_cycles", 32'(en_cnt), 9216);
    check("f3_gap", 32'(gap_cnt), 0);
    check("f3_done", 32'(done_cnt), 1);
    check("f3_seq", 32'(seq_err), 0);
    check("f3_hs", 32'(hs_cnt), 3);
    check("f3_underrun", 32'(underrun), 0);

    // Second word late: underrun, 11-cycle hole, word still sent complete.
    run_frame(8'd2, 1'b1, 1'b0);
    check("late_en_cycles", 32'(en_cnt), 6144);
    check("late_gap", 32'(gap_cnt), 11);
    check("late_underrun", 32'(underrun), 1);
    check("late_done", 32'(done_cnt), 1);
    check("late_seq", 32'(seq_err), 0);

    // start during RUN is ignored; next frame clears underrun.
    run_frame(8'd1, 1'b0, 1'b1);
    check("poke_en_cycles", 32'(en_cnt), 3072);
    check("poke_done", 32'(done_cnt), 1);
    check("poke_seq", 32'(seq_err), 0);
    check("poke_underrun", 32'(underrun), 0);

    // Abort at cnt_out=100 of bit 5.
    s_data = 12'hA5C; s_valid = 1'b1;
    @(negedge clk);
    frame_len = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!(mod_en && bit_idx == 4'd5 && cnt_out == 8'd100) && wait_cyc < 5000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("abort_reach", 32'(wait_cyc < 5000), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    s_valid = 1'b0;
    check("abort_mod_en", 32'(mod_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_cnt", 32'(cnt_out), 0);
    check("abort_bit_hold", 32'(bit_idx), 5);
    check("abort_data_hold", 32'(mod_data), 32'h A5C);
    done_seen = 0;
    repeat (5) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_seen), 0);

    run_frame(8'd1, 1'b0, 1'b0);
    check("post_abort_en", 32'(en_cnt), 3072);
    check("post_abort_done", 32'(done_cnt), 1);

    // Asynchronous reset mid-RUN, between clock edges.
    s_data = 12'hA5C; s_valid = 1'b1;
    @(negedge clk);
    frame_len = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    check("pre_rst_mod_en", 32'(mod_en), 1);
    #2;
    arst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    arst = 1'b0;
    s_valid = 1'b0;
    frame_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    wait_cyc = 0;
    repeat (5) begin
      if (done) done_seen++;
      if (busy) wait_cyc++;
      @(negedge clk);
    end
    check("zero_len_busy", 32'(wait_cyc), 0);
    check("zero_len_done", 32'(done_seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
